// File: rtl/winograd_f2x2_channel_accumulator.sv
// Winograd F(2x2,3x3) channel accumulator: V = B^T d B per beat, U.*V accumulated
// across channels in the transform domain, Y = A^T acc A emitted per tile, saturated.
module winograd_f2x2_channel_accumulator #(
  parameter int DATA_WIDTH   = 32,
  parameter int FRAC_WIDTH   = 16,
  parameter int MAX_CHANNELS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic signed [DATA_WIDTH-1:0] window [16],
  input  logic signed [DATA_WIDTH-1:0] kernel [16],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] result [4],
  output logic                         out_saturated,
  output logic                         out_chan_err
);

  localparam int VW = DATA_WIDTH + 2;
  localparam int MW = 2 * DATA_WIDTH + 2;
  localparam int AW = MW + $clog2(MAX_CHANNELS);
  localparam int YW = AW + 4;
  localparam int NW = $clog2(MAX_CHANNELS + 1);

  typedef logic signed [VW-1:0] v_t;
  typedef logic signed [MW-1:0] m_t;
  typedef logic signed [AW-1:0] a_t;
  typedef logic signed [YW-1:0] y_t;

  logic                         stall, accept, chan_full;
  logic [NW-1:0]                cnt;

  logic                         s0_valid, s0_last, s0_err;
  logic signed [DATA_WIDTH-1:0] s0_d [16];
  logic signed [DATA_WIDTH-1:0] s0_u [16];

  logic                         s1_valid, s1_last, s1_err;
  v_t                           s1_v [16];
  logic signed [DATA_WIDTH-1:0] s1_u [16];

  a_t                           acc [16];

  v_t                           t [16];
  v_t                           v [16];
  m_t                           m [16];
  a_t                           s [16];
  y_t                           p [8];
  y_t                           y [4];
  y_t                           ys [4];
  logic signed [DATA_WIDTH-1:0] res [4];
  logic                         ovf;
  logic                         sat_any;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !rst && !stall;
  assign accept    = in_valid && in_ready;
  assign chan_full = (cnt == NW'(MAX_CHANNELS - 1));

  // Stage 0: capture beat; the MAX_CHANNELS-th beat force-closes the tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
      s0_err   <= 1'b0;
      cnt      <= '0;
    end else if (!stall) begin
      s0_valid <= accept;
      s0_last  <= in_last || chan_full;
      s0_err   <= !in_last && chan_full;
      if (accept)
        cnt <= (in_last || chan_full) ? '0 : cnt + NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && accept) begin
      s0_d <= window;
      s0_u <= kernel;
    end
  end

  // V = B^T d B: rows first, then columns with the same pattern.
  always_comb begin
    for (int unsigned c = 0; c < 4; c++) begin
      t[c]      = v_t'(s0_d[c])     - v_t'(s0_d[8 + c]);
      t[4 + c]  = v_t'(s0_d[4 + c]) + v_t'(s0_d[8 + c]);
      t[8 + c]  = v_t'(s0_d[8 + c]) - v_t'(s0_d[4 + c]);
      t[12 + c] = v_t'(s0_d[4 + c]) - v_t'(s0_d[12 + c]);
    end
    for (int unsigned r = 0; r < 4; r++) begin
      v[4*r]     = t[4*r]     - t[4*r + 2];
      v[4*r + 1] = t[4*r + 1] + t[4*r + 2];
      v[4*r + 2] = t[4*r + 2] - t[4*r + 1];
      v[4*r + 3] = t[4*r + 1] - t[4*r + 3];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_err   <= 1'b0;
    end else if (!stall) begin
      s1_valid <= s0_valid;
      s1_last  <= s0_last;
      s1_err   <= s0_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_v <= v;
      s1_u <= s0_u;
    end
  end

  // Stage 2: product, running sum, inverse transform, floor shift and clip.
  always_comb begin
    sat_any = 1'b0;
    ovf     = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      m[k] = m_t'(s1_u[k]) * m_t'(s1_v[k]);
      s[k] = acc[k] + a_t'(m[k]);
    end
    for (int unsigned c = 0; c < 4; c++) begin
      p[c]     = y_t'(s[c]) + y_t'(s[4 + c]) + y_t'(s[8 + c]);
      p[4 + c] = y_t'(s[4 + c]) - y_t'(s[8 + c]) - y_t'(s[12 + c]);
    end
    for (int unsigned r = 0; r < 2; r++) begin
      y[2*r]     = p[4*r] + p[4*r + 1] + p[4*r + 2];
      y[2*r + 1] = p[4*r + 1] - p[4*r + 2] - p[4*r + 3];
    end
    for (int unsigned k = 0; k < 4; k++) begin
      ys[k]  = y[k] >>> FRAC_WIDTH;
      ovf    = !((&ys[k][YW-1:DATA_WIDTH-1]) || !(|ys[k][YW-1:DATA_WIDTH-1]));
      res[k] = ys[k][DATA_WIDTH-1:0];
      if (ovf)
        res[k] = ys[k][YW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                             : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat_any = sat_any || ovf;
    end
  end

  // Not stalled implies any pending output is being taken this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_saturated <= 1'b0;
      out_chan_err  <= 1'b0;
      for (int unsigned k = 0; k < 4; k++)  result[k] <= '0;
      for (int unsigned k = 0; k < 16; k++) acc[k]    <= '0;
    end else if (!stall) begin
      if (s1_valid) begin
        for (int unsigned k = 0; k < 16; k++)
          acc[k] <= s1_last ? '0 : s[k];
      end
      if (s1_valid && s1_last) begin
        out_valid     <= 1'b1;
        out_saturated <= sat_any;
        out_chan_err  <= s1_err;
        result        <= res;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
